// File: rtl/decode_issue_stage.sv
// -----------------------------------------------------------------------------
// decode_issue_stage
//   Decode/issue stage between the control decoder and the execute stage.
//   It reads the register file with a same-cycle writeback bypass. A register
//   scoreboard stalls instructions that have RAW or WAW hazards. The stage
//   sign-extends the immediate and forms the branch target. Results are held
//   in a valid/ready output register, so the stage has one cycle of latency.
//
// Ports
//   iClk, iRst_n               clock, synchronous active-low reset
//   iValid / oReady            upstream handshake (issue = iValid & oReady)
//   iSrc0Addr/En, iSrc1Addr/En source operand selects
//   iDstAddr/En                destination register
//   iCallCmd                   call: oMemData carries iNextPC instead of src1
//   iImm, iBrOff, iNextPC      raw immediate, branch offset, PC+1
//   iCtrl                      opaque control bundle, passed through
//   iWbEn/iWbAddr/iWbData      writeback port (RF write + scoreboard clear)
//   iFlush                     squash the instruction held in the output register
//   oValid / iReady            downstream handshake
//   oSrc0, oSrc1, oImm, oBranchAddr, oMemData,
//   oDstAddr, oDstEn, oCtrl, oNextPC  registered issue bundle
//   oBusy                      scoreboard vector (debug)
// -----------------------------------------------------------------------------
module decode_issue_stage #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int IMM_W    = 16,
  parameter int BOFF_W   = 21,
  parameter int CTRL_W   = 32
) (
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic                iValid,
  output logic                oReady,
  input  logic [ADDR_W-1:0]   iSrc0Addr,
  input  logic                iSrc0En,
  input  logic [ADDR_W-1:0]   iSrc1Addr,
  input  logic                iSrc1En,
  input  logic [ADDR_W-1:0]   iDstAddr,
  input  logic                iDstEn,
  input  logic                iCallCmd,
  input  logic [IMM_W-1:0]    iImm,
  input  logic [BOFF_W-1:0]   iBrOff,
  input  logic [DATA_W-1:0]   iNextPC,
  input  logic [CTRL_W-1:0]   iCtrl,
  input  logic                iWbEn,
  input  logic [ADDR_W-1:0]   iWbAddr,
  input  logic [DATA_W-1:0]   iWbData,
  input  logic                iFlush,
  output logic                oValid,
  input  logic                iReady,
  output logic [DATA_W-1:0]   oSrc0,
  output logic [DATA_W-1:0]   oSrc1,
  output logic [DATA_W-1:0]   oImm,
  output logic [DATA_W-1:0]   oBranchAddr,
  output logic [DATA_W-1:0]   oMemData,
  output logic [ADDR_W-1:0]   oDstAddr,
  output logic                oDstEn,
  output logic [CTRL_W-1:0]   oCtrl,
  output logic [DATA_W-1:0]   oNextPC,
  output logic [NUM_REGS-1:0] oBusy
);

  logic [DATA_W-1:0]   regFile [NUM_REGS];
  logic [NUM_REGS-1:0] sb;
  logic [NUM_REGS-1:0] sbNext;
  logic [NUM_REGS-1:0] wbMask;
  logic [NUM_REGS-1:0] busyVec;
  logic                hazard;
  logic                issue;
  logic [DATA_W-1:0]   src0Val;
  logic [DATA_W-1:0]   src1Val;
  logic [DATA_W-1:0]   immExt;
  logic [DATA_W-1:0]   brOffExt;

  // A writeback in flight this cycle releases its register immediately, so a
  // waiting consumer issues in the same cycle and picks up the bypassed data.
  // NOTE: every variable written in always_comb gets a default first; a path
  // that leaves one unassigned infers a latch.
  always_comb begin
    wbMask = '0;
    if (iWbEn) wbMask[iWbAddr] = 1'b1;
    busyVec = sb & ~wbMask;
    hazard  = (iSrc0En & busyVec[iSrc0Addr])
            | (iSrc1En & busyVec[iSrc1Addr])
            | (iDstEn  & busyVec[iDstAddr]);
  end

  assign oReady = !hazard && (!oValid || iReady) && !iFlush;
  assign issue  = iValid && oReady;

  // Operand read. Register 0 always reads zero, even when a writeback names it.
  always_comb begin
    src0Val = '0;
    if (iSrc0En && iSrc0Addr != '0)
      src0Val = (iWbEn && iWbAddr == iSrc0Addr) ? iWbData : regFile[iSrc0Addr];
    src1Val = '0;
    if (iSrc1En && iSrc1Addr != '0)
      src1Val = (iWbEn && iWbAddr == iSrc1Addr) ? iWbData : regFile[iSrc1Addr];
  end

  assign immExt   = {{(DATA_W-IMM_W){iImm[IMM_W-1]}}, iImm};
  assign brOffExt = {{(DATA_W-BOFF_W){iBrOff[BOFF_W-1]}}, iBrOff};

  // The clears are applied first and the issue set last, so a set and a clear
  // of the same register in one cycle leaves it busy.
  always_comb begin
    sbNext = sb;
    if (iWbEn) sbNext[iWbAddr] = 1'b0;
    if (iFlush && oValid && oDstEn) sbNext[oDstAddr] = 1'b0;
    if (issue && iDstEn && iDstAddr != '0) sbNext[iDstAddr] = 1'b1;
    sbNext[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge iClk) begin
    if (!iRst_n) sb <= '0;
    else         sb <= sbNext;
  end

  assign oBusy = sb;

  // NOTE: the register file is cleared on reset because architectural
  // registers must read zero after reset; that costs a reset on every word.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regFile[i] <= '0;
    end else if (iWbEn && iWbAddr != '0) begin
      regFile[iWbAddr] <= iWbData;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      oValid      <= 1'b0;
      oSrc0       <= '0;
      oSrc1       <= '0;
      oImm        <= '0;
      oBranchAddr <= '0;
      oMemData    <= '0;
      oDstAddr    <= '0;
      oDstEn      <= 1'b0;
      oCtrl       <= '0;
      oNextPC     <= '0;
    end else if (issue) begin
      oValid      <= 1'b1;
      oSrc0       <= src0Val;
      oSrc1       <= src1Val;
      oImm        <= immExt;
      oBranchAddr <= iNextPC + brOffExt;
      oMemData    <= iCallCmd ? iNextPC : src1Val;
      oDstAddr    <= iDstAddr;
      oDstEn      <= iDstEn;
      oCtrl       <= iCtrl;
      oNextPC     <= iNextPC;
    end else if (iFlush || iReady) begin
      // Consumed downstream or squashed; the data fields may keep stale values.
      oValid <= 1'b0;
    end
  end

endmodule
